// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA scan-out path.
// Top-level parameters default to these values.
package vga_pkg;

    typedef logic [7:0]  pixel_t;
    typedef logic [9:0]  coord_t;
    typedef logic [23:0] rgb_t;

    localparam int VGA_H_VIS  = 640;
    localparam int VGA_H_FP   = 16;
    localparam int VGA_H_SYNC = 96;
    localparam int VGA_H_BP   = 48;
    localparam int VGA_V_VIS  = 480;
    localparam int VGA_V_FP   = 10;
    localparam int VGA_V_SYNC = 2;
    localparam int VGA_V_BP   = 33;

    localparam int VGA_IMG_W  = 256;
    localparam int VGA_IMG_H  = 256;
    localparam int VGA_IMG_X0 = 192;
    localparam int VGA_IMG_Y0 = 112;

    localparam logic [31:0] VGA_BASE0 = 32'd0;
    localparam logic [31:0] VGA_BASE1 = 32'd65536;

    localparam int H_TOTAL  = VGA_H_VIS + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int V_TOTAL  = VGA_V_VIS + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int HS_START = VGA_H_VIS + VGA_H_FP;
    localparam int HS_END   = HS_START + VGA_H_SYNC;
    localparam int VS_START = VGA_V_VIS + VGA_V_FP;
    localparam int VS_END   = VS_START + VGA_V_SYNC;

endpackage

// File: rtl/vga_timing_counter.sv
// Stage-0 raster counters with raw (undelayed) sync and visible decode.
// Counts wrap at the end of each line and at the end of the last line.
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int H_VIS  = VGA_H_VIS,
    parameter int H_FP   = VGA_H_FP,
    parameter int H_SYNC = VGA_H_SYNC,
    parameter int H_BP   = VGA_H_BP,
    parameter int V_VIS  = VGA_V_VIS,
    parameter int V_FP   = VGA_V_FP,
    parameter int V_SYNC = VGA_V_SYNC,
    parameter int V_BP   = VGA_V_BP
) (
    input  logic       clk,
    input  logic       i_rst_n,
    output logic [9:0] o_h,
    output logic [9:0] o_v,
    output logic       o_hsync_n,
    output logic       o_vsync_n,
    output logic       o_visible
);

    localparam coord_t H_MAX = coord_t'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_MAX = coord_t'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t HS_B  = coord_t'(H_VIS + H_FP);
    localparam coord_t HS_E  = coord_t'(H_VIS + H_FP + H_SYNC);
    localparam coord_t VS_B  = coord_t'(V_VIS + V_FP);
    localparam coord_t VS_E  = coord_t'(V_VIS + V_FP + V_SYNC);
    localparam coord_t HV    = coord_t'(H_VIS);
    localparam coord_t VV    = coord_t'(V_VIS);

    coord_t r_h;
    coord_t r_v;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == H_MAX) begin
            r_h <= '0;
            r_v <= (r_v == V_MAX) ? '0 : r_v + 10'd1;
        end else begin
            r_h <= r_h + 10'd1;
        end
    end

    assign o_h       = r_h;
    assign o_v       = r_v;
    assign o_hsync_n = !(r_h >= HS_B && r_h < HS_E);
    assign o_vsync_n = !(r_v >= VS_B && r_v < VS_E);
    assign o_visible = (r_h < HV) && (r_v < VV);

endmodule

// File: rtl/vga_scanout_engine.sv
// Pixel-clock scan-out: window address generation, framebuffer fetch and
// a two-stage pipeline keeping sync, frame pulse and pixel data aligned.
module vga_scanout_engine
    import vga_pkg::*;
#(
    parameter int          H_VIS  = VGA_H_VIS,
    parameter int          H_FP   = VGA_H_FP,
    parameter int          H_SYNC = VGA_H_SYNC,
    parameter int          H_BP   = VGA_H_BP,
    parameter int          V_VIS  = VGA_V_VIS,
    parameter int          V_FP   = VGA_V_FP,
    parameter int          V_SYNC = VGA_V_SYNC,
    parameter int          V_BP   = VGA_V_BP,
    parameter int          IMG_W  = VGA_IMG_W,
    parameter int          IMG_H  = VGA_IMG_H,
    parameter int          IMG_X0 = VGA_IMG_X0,
    parameter int          IMG_Y0 = VGA_IMG_Y0,
    parameter logic [31:0] BASE0  = VGA_BASE0,
    parameter logic [31:0] BASE1  = VGA_BASE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        image_select,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] rgb_out,
    output logic        frame_start
);

    localparam coord_t WX0 = coord_t'(IMG_X0);
    localparam coord_t WX1 = coord_t'(IMG_X0 + IMG_W);
    localparam coord_t WY0 = coord_t'(IMG_Y0);
    localparam coord_t WY1 = coord_t'(IMG_Y0 + IMG_H);

    coord_t      w_h;
    coord_t      w_v;
    logic        w_hs_n;
    logic        w_vs_n;
    logic        w_vis;
    logic        w_in_win;
    logic        w_frame;

    logic [31:0] r_addr;
    logic [31:0] r_last;
    logic        r_win1;
    logic        r_hs1;
    logic        r_vs1;
    logic        r_fs1;
    rgb_t        r_rgb;
    logic        r_hs2;
    logic        r_vs2;
    logic        r_fs2;
    pixel_t      w_pix;

    vga_timing_counter #(
        .H_VIS  (H_VIS),
        .H_FP   (H_FP),
        .H_SYNC (H_SYNC),
        .H_BP   (H_BP),
        .V_VIS  (V_VIS),
        .V_FP   (V_FP),
        .V_SYNC (V_SYNC),
        .V_BP   (V_BP)
    ) u_tc (
        .clk       (clk),
        .i_rst_n   (reset),
        .o_h       (w_h),
        .o_v       (w_v),
        .o_hsync_n (w_hs_n),
        .o_vsync_n (w_vs_n),
        .o_visible (w_vis)
    );

    assign w_in_win = w_vis && (w_h >= WX0) && (w_h < WX1)
                      && (w_v >= WY0) && (w_v < WY1);
    assign w_frame  = (w_h == '0) && (w_v == '0);

    // r_addr is the next window read; selecting the base at (0,0) only
    // keeps a whole frame on one image even if image_select moves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= BASE0;
            r_last <= BASE0;
        end else if (w_frame) begin
            r_addr <= image_select ? BASE1 : BASE0;
        end else if (w_in_win) begin
            r_addr <= r_addr + 32'd1;
            r_last <= r_addr;
        end
    end

    assign mem_addr = w_in_win ? r_addr : r_last;
    assign w_pix    = mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_win1 <= 1'b0;
            r_hs1  <= 1'b1;
            r_vs1  <= 1'b1;
            r_fs1  <= 1'b0;
            r_rgb  <= '0;
            r_hs2  <= 1'b1;
            r_vs2  <= 1'b1;
            r_fs2  <= 1'b0;
        end else begin
            r_win1 <= w_in_win;
            r_hs1  <= w_hs_n;
            r_vs1  <= w_vs_n;
            r_fs1  <= w_frame;
            r_rgb  <= r_win1 ? {w_pix, w_pix, w_pix} : '0;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_fs2  <= r_fs1;
        end
    end

    assign rgb_out     = r_rgb;
    assign hsync       = r_hs2;
    assign vsync       = r_vs2;
    assign frame_start = r_fs2;

endmodule

// File: tb/tb_vga_scanout_engine.sv
// Bench: a shrunken-geometry instance covers whole frames and the window,
// a default-geometry instance covers the standard line timing.
module tb_vga_scanout_engine;

    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int w;  int h;  int x0; int y0;
    } geom_t;

    localparam geom_t GS = '{40, 4, 8, 6, 30, 2, 2, 3, 16, 8, 10, 5};
    localparam geom_t GD = '{640, 16, 96, 48, 480, 10, 2, 33,
                             256, 256, 192, 112};
    localparam logic [31:0] B0 = 32'd0;
    localparam logic [31:0] B1 = 32'd65536;
    localparam int FRS = (40 + 4 + 8 + 6) * (30 + 2 + 2 + 3);

    logic        clk;
    logic        reset;
    logic        image_select;
    logic [31:0] a_s, a_d;
    logic [7:0]  rd_s, rd_d;
    logic        hs_s, vs_s, fs_s, hs_d, vs_d, fs_d;
    logic [23:0] rgb_s, rgb_d;

    int          n_chk = 0;
    int          n_ok  = 0;
    int          k;
    logic        sel_s, sel_d;
    logic [31:0] last_s, last_d;

    vga_scanout_engine #(
        .H_VIS(GS.hv), .H_FP(GS.hf), .H_SYNC(GS.hs), .H_BP(GS.hb),
        .V_VIS(GS.vv), .V_FP(GS.vf), .V_SYNC(GS.vs), .V_BP(GS.vb),
        .IMG_W(GS.w), .IMG_H(GS.h), .IMG_X0(GS.x0), .IMG_Y0(GS.y0),
        .BASE0(B0), .BASE1(B1)
    ) u_small (
        .clk(clk), .reset(reset), .image_select(image_select),
        .mem_addr(a_s), .mem_rdata(rd_s), .hsync(hs_s), .vsync(vs_s),
        .rgb_out(rgb_s), .frame_start(fs_s)
    );

    vga_scanout_engine u_std (
        .clk(clk), .reset(reset), .image_select(image_select),
        .mem_addr(a_d), .mem_rdata(rd_d), .hsync(hs_d), .vsync(vs_d),
        .rgb_out(rgb_d), .frame_start(fs_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] pix(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ {7'b0, a[16]};
    endfunction

    always @(posedge clk) begin
        rd_s <= pix(a_s);
        rd_d <= pix(a_d);
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s got=%0h exp=%0h (k=%0d)", tag, got, exp, k);
    endtask

    function automatic bit in_win(input geom_t g, input int x, input int y);
        return x >= g.x0 && x < g.x0 + g.w && y >= g.y0 && y < g.y0 + g.h;
    endfunction

    // Reference: cycle k after release scans raster position k mod frame;
    // outputs show position k-2; window pixel n of the frame reads base+n.
    task automatic eval(input string nm, input geom_t g, input int kk,
                        input logic sel, input logic [31:0] a,
                        input logic h, input logic v,
                        input logic [23:0] rgb, input logic fs,
                        inout logic [31:0] last);
        int ht, fr, q, x, y;
        logic [31:0] base, ea;
        logic eh, ev, ef;
        logic [23:0] er;
        ht = g.hv + g.hf + g.hs + g.hb;
        fr = ht * (g.vv + g.vf + g.vs + g.vb);
        base = sel ? B1 : B0;
        q = kk % fr; x = q % ht; y = q / ht;
        ea = last;
        if (in_win(g, x, y))
            ea = base + 32'((y - g.y0) * g.w + (x - g.x0));
        chk({nm, " mem_addr"}, a, ea);
        last = ea;
        eh = 1'b1; ev = 1'b1; ef = 1'b0; er = '0;
        if (kk >= 2) begin
            q = (kk - 2) % fr; x = q % ht; y = q / ht;
            eh = !(x >= g.hv + g.hf && x < g.hv + g.hf + g.hs);
            ev = !(y >= g.vv + g.vf && y < g.vv + g.vf + g.vs);
            ef = (q == 0);
            if (in_win(g, x, y))
                er = {3{pix(base + 32'((y - g.y0) * g.w + (x - g.x0)))}};
        end
        chk({nm, " hsync"}, 32'(h), 32'(eh));
        chk({nm, " vsync"}, 32'(v), 32'(ev));
        chk({nm, " frame_start"}, 32'(fs), 32'(ef));
        chk({nm, " rgb_out"}, 32'(rgb), 32'(er));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " S mem_addr"}, a_s, B0);
        chk({tag, " S hsync"}, 32'(hs_s), 32'd1);
        chk({tag, " S vsync"}, 32'(vs_s), 32'd1);
        chk({tag, " S rgb_out"}, 32'(rgb_s), 32'd0);
        chk({tag, " S frame_start"}, 32'(fs_s), 32'd0);
        chk({tag, " D mem_addr"}, a_d, B0);
        chk({tag, " D hsync"}, 32'(hs_d), 32'd1);
        chk({tag, " D vsync"}, 32'(vs_d), 32'd1);
        chk({tag, " D rgb_out"}, 32'(rgb_d), 32'd0);
    endtask

    task automatic run(input int n);
        int q;
        for (int i = 0; i < n; i++) begin
            q = k % FRS;
            if (q >= 100 && q < FRS - 10 && $urandom_range(0, 149) == 0)
                image_select = ~image_select;
            if (q == FRS - 5) image_select = ~sel_s;
            if (q == 0) sel_s = image_select;
            if (k == 0) sel_d = image_select;
            eval("S", GS, k, sel_s, a_s, hs_s, vs_s, rgb_s, fs_s, last_s);
            eval("D", GD, k, sel_d, a_d, hs_d, vs_d, rgb_d, fs_d, last_d);
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        k = 0;
        last_s = B0;
        last_d = B0;
    endtask

    initial begin
        reset = 1'b0;
        image_select = 1'b0;
        k = 0;
        sel_s = 1'b0;
        sel_d = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        release_reset();
        run(2 * FRS + 7 * 58 + 15);
        reset = 1'b0;
        #1;
        check_reset("mid");
        repeat (2) begin
            @(negedge clk);
            check_reset("hold");
        end
        image_select = 1'b1;
        release_reset();
        run(2 * FRS + 100);
        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_scanout_engine.md
Name: vga_scanout_engine

Overview:
Pixel-clock scan-out stage sitting directly upstream of the VGA DAC pins of graphics_controller. Generates 640x480@60 timing and fetches 8-bit grayscale pixels from the image framebuffer (synchronous read, 1-cycle latency). Places a fixed IMG_W x IMG_H window on screen, selects the original or interpolated image via image_select, and drives hsync/vsync/rgb_out pipeline-aligned.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_VIS, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
IMG_W, 256, image window width (pixels)
IMG_H, 256, image window height (lines)
IMG_X0, 192, window left column
IMG_Y0, 112, window top line
BASE0, 32'd0, framebuffer base of original image
BASE1, 32'd65536, framebuffer base of interpolated image

Ports:
clk  in  1  pixel clock (25.175 MHz nominal)
reset  in  1  asynchronous, active-low reset
image_select  in  1  0 = BASE0 image, 1 = BASE1 image
mem_addr  out  32  framebuffer read address
mem_rdata  in  8  framebuffer read data, valid 1 cycle after mem_addr
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
rgb_out  out  24  {R,G,B}, 8 bits each
frame_start  out  1  1-cycle pulse aligned with output pixel (0,0)

Behaviour:
- Reset (reset=0, async): h_cnt=0, v_cnt=0, pipeline flushed; hsync=1, vsync=1, rgb_out=0, frame_start=0, mem_addr=BASE0, latched select=0. Release resumes scanning at (0,0) on the first clk edge.
- Stage 0 counters: h_cnt 0..H_TOTAL-1 (800), wraps to 0 and increments v_cnt; v_cnt 0..V_TOTAL-1 (525), wraps to 0 at h wrap of last line.
- Sync decode on stage-0 counts: hsync_n=0 iff H_VIS+H_FP <= h_cnt < H_VIS+H_FP+H_SYNC (656..751); vsync_n=0 iff 490 <= v_cnt < 492.
- in_win = IMG_X0<=h_cnt<IMG_X0+IMG_W and IMG_Y0<=v_cnt<IMG_Y0+IMG_H.
- Address: running counter, no multiplier. At (0,0) latch sel=image_select and set addr_base to BASE0/BASE1; addr advances by 1 for each in_win pixel; mem_addr = current addr while in_win, holds last value otherwise. First window pixel reads base, last reads base+IMG_W*IMG_H-1.
- image_select is sampled only at h_cnt=0,v_cnt=0; mid-frame changes take effect next frame (no tearing).
- Stage 1: mem_rdata valid; in_win/hsync/vsync/frame flag delayed one register.
- Stage 2 (output regs): rgb_out = {d,d,d} if delayed in_win, else 24'h000000 (including all blanking). hsync, vsync, frame_start registered here.
- Latency: counter position (x,y) appears on outputs exactly 2 clk later; syncs delayed identically so timing relative to pixels is standard.
- Frame period 420000 clk; line period 800 clk.
- Reset mid-frame: all state cleared immediately, outputs at reset values, frame restarts from (0,0) with fresh select latch.

Decomposition:
- Package vga_pkg: timing constants (H_TOTAL, V_TOTAL, sync start/end), typedef pixel_t (logic[7:0]), typedef coord_t (logic[9:0]), typedef rgb_t (logic[23:0]).
- Sub-module vga_timing_counter: h/v counters, wrap, raw hsync_n/vsync_n, visible flag. Top adds window/address logic and 2-stage alignment pipeline.

Test Plan:
- Reset held low then released -> hsync=1, vsync=1, rgb_out=0, mem_addr=0 during reset; frame_start pulses at cycle 2 after release.
- Free run 2 lines -> hsync period 800 clk, low for 96 clk starting 656+2 clk after line start; rgb_out=0 in blanking.
- Full frame -> vsync period 420000 clk, low for 1600 clk; frame_start exactly once per frame.
- image_select=0, memory model returns addr[7:0] -> at (192,112) mem_addr=0, at (447,367) mem_addr=65535; rgb_out=0x5A5A5A two cycles after the read of address 0x..5A; pixel (191,112) and (448,112) -> rgb_out=0.
- image_select toggled to 1 mid-frame -> addresses stay in BASE0 range until next frame; next frame first window read = 65536.
- reset pulsed low at (300,200) -> outputs immediately at reset values; after release counters restart at (0,0), timing checks pass.
